dmem_arb: RTL and testbench

//  Data-memory arbiter/scheduler: shares the single-port data memory between the PU load/store path
//  (driven by the decoder's dmwe/dms control) and a host/debug port used to preload and inspect memory.
//  The PU has fixed priority; an anti-starvation counter guarantees the host periodic slots.
//  c_stall freezes the PU (PC and register writes) while it is denied. Sits between pu and dmem.

---
 rtl/dmem_arb.sv | 145 ++++++++++++++
 tb/tb_dmem_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// Data-memory arbiter: PU (fixed priority, anti-starvation) vs host/debug port; optional host bursts under HOST_BURST_EN.
// Latency: grant and memory access are combinational in the request cycle; h_rd/h_rv are registered one cycle after a host read beat.
// Backpressure: a denied PU sees c_stall and retries; the host holds h_req until h_gnt (dropping h_req mid-burst aborts the burst).
module dmem_arb #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int STARVE   = 4,
    parameter int MAXBURST = 8,
    localparam int BLW     = $clog2(MAXBURST) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           c_req,
    input  logic           c_we,
    input  logic [AW-1:0]  c_ad,
    input  logic [DW-1:0]  c_wd,
    output logic [DW-1:0]  c_rd,
    output logic           c_stall,
    input  logic           h_req,
    input  logic           h_we,
    input  logic [AW-1:0]  h_ad,
    input  logic [DW-1:0]  h_wd,
    input  logic [BLW-1:0] h_blen,
    output logic           h_gnt,
    output logic [DW-1:0]  h_rd,
    output logic           h_rv,
    output logic           m_we,
    output logic [AW-1:0]  m_ad,
    output logic [DW-1:0]  m_wd,
    input  logic [DW-1:0]  m_rd,
    output logic           owner
);

    localparam int SCW = $clog2(STARVE + 1);

    logic [SCW-1:0] stcnt;
    logic           starved;
    logic           arb_idle;
    logic           pu_win;
    logic           host_beat;
    logic           host_we;
    logic [AW-1:0]  host_ad;

`ifdef HOST_BURST_EN
    typedef enum logic {IDLE, BURST} state_t;

    state_t         state;
    logic [AW-1:0]  baddr;
    logic [BLW-1:0] bcnt;
    logic           bwe;
    logic [BLW-1:0] blen_eff;

    always_comb begin
        blen_eff = h_blen;
        if (h_blen == '0)
            blen_eff = BLW'(1);
        else if (h_blen > BLW'(MAXBURST))
            blen_eff = BLW'(MAXBURST);
    end

    assign arb_idle = (state == IDLE);
    // Burst beats use the latched direction and the internal address counter.
    assign host_we  = arb_idle ? h_we : bwe;
    assign host_ad  = arb_idle ? h_ad : baddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
            baddr <= '0;
            bwe   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_beat && blen_eff > BLW'(1)) begin
                        state <= BURST;
                        bcnt  <= blen_eff - BLW'(1);
                        baddr <= h_ad + AW'(1);
                        bwe   <= h_we;
                    end
                end
                BURST: begin
                    if (!h_req) begin
                        state <= IDLE;
                        bcnt  <= '0;
                    end else begin
                        baddr <= baddr + AW'(1);
                        bcnt  <= bcnt - BLW'(1);
                        if (bcnt == BLW'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_blen;

    assign unused_blen = ^h_blen;
    assign arb_idle    = 1'b1;
    assign host_we     = h_we;
    assign host_ad     = h_ad;
`endif

    assign starved   = h_req && (stcnt == SCW'(STARVE));
    assign pu_win    = !rst && arb_idle && c_req && !starved;
    assign host_beat = !rst && h_req && !pu_win;

    always_comb begin
        m_we = 1'b0;
        m_ad = c_ad;
        m_wd = c_wd;
        if (pu_win) begin
            m_we = c_we;
        end else if (host_beat) begin
            m_we = host_we;
            m_ad = host_ad;
            m_wd = h_wd;
        end
    end

    assign owner   = host_beat;
    assign h_gnt   = host_beat;
    assign c_stall = c_req & ~pu_win;
    assign c_rd    = m_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            stcnt <= '0;
            h_rv  <= 1'b0;
            h_rd  <= '0;
        end else begin
            h_rv <= host_beat && !host_we;
            if (host_beat && !host_we)
                h_rd <= m_rd;
            // Counts PU wins only while the host is waiting; any host beat or idle host resets it.
            if (host_beat || !h_req || !arb_idle)
                stcnt <= '0;
            else if (pu_win && stcnt != SCW'(STARVE))
                stcnt <= stcnt + SCW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a behavioural asynchronous-read memory; works with or without HOST_BURST_EN.
module tb_dmem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we;
    logic [7:0]  c_ad;
    logic [15:0] c_wd, c_rd;
    logic        c_stall;
    logic        h_req, h_we;
    logic [7:0]  h_ad;
    logic [15:0] h_wd;
    logic [3:0]  h_blen;
    logic        h_gnt;
    logic [15:0] h_rd;
    logic        h_rv;
    logic        m_we;
    logic [7:0]  m_ad;
    logic [15:0] m_wd, m_rd;
    logic        owner;

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (m_we) mem[m_ad] <= m_wd;
    assign m_rd = mem[m_ad];

    dmem_arb dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_ad(c_ad), .c_wd(c_wd), .c_rd(c_rd), .c_stall(c_stall),
        .h_req(h_req), .h_we(h_we), .h_ad(h_ad), .h_wd(h_wd), .h_blen(h_blen),
        .h_gnt(h_gnt), .h_rd(h_rd), .h_rv(h_rv),
        .m_we(m_we), .m_ad(m_ad), .m_wd(m_wd), .m_rd(m_rd), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst = 1'b1; c_req = 1'b1; c_we = 1'b1; c_ad = 8'h0; c_wd = 16'h0;
        h_req = 1'b1; h_we = 1'b1; h_ad = 8'h0; h_wd = 16'h0; h_blen = 4'd1;

        // Reset with both requesters active
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_m_we", m_we, 0);
            chk("rst_h_gnt", h_gnt, 0);
            chk("rst_c_stall", c_stall, 1);
            chk("rst_owner", owner, 0);
            chk("rst_h_rv", h_rv, 0);
        end

        // PU write then read back
        @(negedge clk);
        rst = 1'b0; h_req = 1'b0; c_req = 1'b1; c_we = 1'b1; c_ad = 8'h10; c_wd = 16'h1234;
        #1;
        chk("pu_wr_m_we", m_we, 1);
        chk("pu_wr_m_ad", m_ad, 8'h10);
        chk("pu_wr_m_wd", m_wd, 16'h1234);
        chk("pu_wr_stall", c_stall, 0);
        chk("pu_wr_owner", owner, 0);
        @(negedge clk);
        c_we = 1'b0;
        #1;
        chk("pu_rd_c_rd", c_rd, 16'h1234);
        chk("pu_rd_m_we", m_we, 0);

        // Host read
        @(negedge clk);
        c_req = 1'b0; h_req = 1'b1; h_we = 1'b0; h_ad = 8'h10;
        #1;
        chk("h_rd_gnt", h_gnt, 1);
        chk("h_rd_owner", owner, 1);
        chk("h_rd_m_ad", m_ad, 8'h10);
        chk("h_rd_m_we", m_we, 0);
        @(negedge clk);
        h_req = 1'b0;
        #1;
        chk("h_rv_pulse", h_rv, 1);
        chk("h_rd_data", h_rd, 16'h1234);
        chk("h_gnt_idle", h_gnt, 0);
        @(negedge clk);
        #1;
        chk("h_rv_clear", h_rv, 0);

        // Host write gives no h_rv; PU reads it back
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b1; h_ad = 8'h20; h_wd = 16'hBEEF;
        #1;
        chk("h_wr_gnt", h_gnt, 1);
        chk("h_wr_m_we", m_we, 1);
        chk("h_wr_m_wd", m_wd, 16'hBEEF);
        @(negedge clk);
        h_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_ad = 8'h20;
        #1;
        chk("h_wr_no_rv", h_rv, 0);
        chk("pu_rd_beef", c_rd, 16'hBEEF);

        // Both requesting continuously: host every fifth cycle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b0; c_ad = 8'h10;
            h_req = 1'b1; h_we = 1'b0; h_ad = 8'h20;
            #1;
            chk($sformatf("starve_owner_%0d", i), owner, (i % 5 == 4));
            chk($sformatf("starve_stall_%0d", i), c_stall, (i % 5 == 4));
            chk($sformatf("starve_hrv_%0d", i), h_rv, (i % 5 == 0 && i > 0));
            if (i == 5) chk("starve_h_rd", h_rd, 16'hBEEF);
        end

        // Dropping h_req clears the starvation count
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            h_req = (i != 2);
            #1;
            chk($sformatf("stclr_owner_%0d", i), owner, (i == 7));
        end
        @(negedge clk);
        c_req = 1'b0; h_req = 1'b0;

        // Host write burst request at 0xFE, after four PU wins while pending
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b0; c_ad = 8'h10;
            h_req = 1'b1; h_we = 1'b1; h_ad = 8'hFE; h_blen = 4'd3; h_wd = 16'hA0;
            #1;
            chk($sformatf("bst_pre_owner_%0d", i), owner, 0);
        end
        @(negedge clk);
        #1;
        chk("bst_b0_owner", owner, 1);
        chk("bst_b0_m_ad", m_ad, 8'hFE);
        chk("bst_b0_m_we", m_we, 1);
        chk("bst_b0_m_wd", m_wd, 16'hA0);
        chk("bst_b0_stall", c_stall, 1);
`ifdef HOST_BURST_EN
        @(negedge clk);
        h_wd = 16'hA1;
        #1;
        chk("bst_b1_owner", owner, 1);
        chk("bst_b1_m_ad", m_ad, 8'hFF);
        chk("bst_b1_m_wd", m_wd, 16'hA1);
        chk("bst_b1_stall", c_stall, 1);
        @(negedge clk);
        h_wd = 16'hA2;
        #1;
        chk("bst_b2_owner", owner, 1);
        chk("bst_b2_m_ad", m_ad, 8'h00);
        chk("bst_b2_gnt", h_gnt, 1);
        chk("bst_b2_stall", c_stall, 1);
        @(negedge clk);
        h_req = 1'b0;
        #1;
        chk("bst_end_owner", owner, 0);
        chk("bst_end_stall", c_stall, 0);
        chk("bst_end_m_ad", m_ad, 8'h10);
`else
        @(negedge clk);
        h_wd = 16'hA1;
        #1;
        chk("single_owner", owner, 0);
        chk("single_stall", c_stall, 0);
        chk("single_m_ad", m_ad, 8'h10);
        chk("single_gnt", h_gnt, 0);
        @(negedge clk);
        h_req = 1'b0;
`endif
        @(negedge clk);
        c_ad = 8'hFE;
        #1;
        chk("mem_fe", c_rd, 16'hA0);
`ifdef HOST_BURST_EN
        @(negedge clk);
        c_ad = 8'hFF;
        #1;
        chk("mem_ff", c_rd, 16'hA1);
        @(negedge clk);
        c_ad = 8'h00;
        #1;
        chk("mem_00", c_rd, 16'hA2);

        // Burst of 5 aborted by dropping h_req after two beats
        @(negedge clk);
        c_req = 1'b0; h_req = 1'b1; h_we = 1'b1; h_ad = 8'h40; h_blen = 4'd5; h_wd = 16'hB0;
        #1;
        chk("abt_b0_m_ad", m_ad, 8'h40);
        @(negedge clk);
        h_wd = 16'hB1;
        #1;
        chk("abt_b1_m_ad", m_ad, 8'h41);
        chk("abt_b1_owner", owner, 1);
        @(negedge clk);
        h_req = 1'b0;
        #1;
        chk("abt_m_we", m_we, 0);
        chk("abt_gnt", h_gnt, 0);
        chk("abt_owner", owner, 0);
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_ad = 8'h41;
        #1;
        chk("abt_idle_stall", c_stall, 0);
        chk("abt_mem_41", c_rd, 16'hB1);
        @(negedge clk);
        c_ad = 8'h42;
        #1;
        chk("abt_mem_42", c_rd, 16'h0);

        // Same burst cut by reset after two beats
        @(negedge clk);
        c_req = 1'b0; h_req = 1'b1; h_we = 1'b1; h_ad = 8'h50; h_wd = 16'hC0;
        #1;
        chk("rab_b0_owner", owner, 1);
        @(negedge clk);
        h_wd = 16'hC1;
        #1;
        chk("rab_b1_m_ad", m_ad, 8'h51);
        @(negedge clk);
        rst = 1'b1; c_req = 1'b1; h_wd = 16'hC2;
        #1;
        chk("rab_m_we", m_we, 0);
        chk("rab_owner", owner, 0);
        chk("rab_gnt", h_gnt, 0);
        chk("rab_stall", c_stall, 1);
        @(negedge clk);
        rst = 1'b0; h_req = 1'b0; c_we = 1'b0; c_ad = 8'h52;
        #1;
        chk("rab_h_rv", h_rv, 0);
        chk("rab_pu_stall", c_stall, 0);
        chk("rab_mem_52", c_rd, 16'h0);
        @(negedge clk);
        c_ad = 8'h51;
        #1;
        chk("rab_mem_51", c_rd, 16'hC1);
`endif
        @(negedge clk);
        c_req = 1'b0; h_req = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
